// File: rtl/serial_shift_responder_pkg.sv
// Package: serial_shift_pkg
// Purpose : Shared types, defaults and helpers for the serial shift responder.
//   state_t   - responder FSM states (IDLE, SHIFT, DONE)
//   DATA_WIDTH_DEF / SHIFT_AMT_DEF - default parameter values
//   cntWidth  - width of the shift-distance counter for an n-bit operand
package serial_shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned SHIFT_AMT_DEF  = 5;

    // One extra bit so the counter can hold the full range 0..n.
    function automatic int unsigned cntWidth(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_shift_responder_if.sv
// Interface: serial_shift_responder_if
// Purpose  : Operand/result handshake bundle between a requester and the
//            serial shift responder.
// Signals:
//   inValid, inputSignal, outReady   - driven by the requester (master)
//   inReady, outValid, result, busy  - driven by the responder (slave)
//   overflow                         - responder output, present only when
//                                      SERIAL_SHIFT_OVF_EN is defined
// Modports: master (requester side), slave (responder side).
interface serial_shift_responder_if
    import serial_shift_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  inValid;
    logic                  inReady;
    logic [DATA_WIDTH-1:0] inputSignal;
    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] result;
    logic                  busy;
`ifdef SERIAL_SHIFT_OVF_EN
    logic                  overflow;

    modport master (
        output inValid, inputSignal, outReady,
        input  inReady, outValid, result, busy, overflow
    );

    modport slave (
        input  inValid, inputSignal, outReady,
        output inReady, outValid, result, busy, overflow
    );
`else
    modport master (
        output inValid, inputSignal, outReady,
        input  inReady, outValid, result, busy
    );

    modport slave (
        input  inValid, inputSignal, outReady,
        output inReady, outValid, result, busy
    );
`endif

endinterface

// File: rtl/serial_shift_responder.sv
// Module : serial_shift_responder
// Purpose: Accepts one operand per valid/ready handshake, shifts it left by
//          SHIFT_AMT one bit per clock, and returns the truncated result on a
//          back-pressurable valid/ready result channel.
// Parameters:
//   DATA_WIDTH - operand/result width
//   SHIFT_AMT  - left-shift distance, 0..DATA_WIDTH-1
// Ports:
//   clk    - rising-edge clock
//   resetN - synchronous active-low reset
//   bus    - serial_shift_responder_if.slave (inValid/inReady/inputSignal,
//            outValid/outReady/result, busy, optional overflow)
// Build option: SERIAL_SHIFT_OVF_EN adds the overflow output, set when any
//   bit shifted past the MSB was 1.
module serial_shift_responder
    import serial_shift_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned SHIFT_AMT  = SHIFT_AMT_DEF
) (
    input logic                     clk,
    input logic                     resetN,
    serial_shift_responder_if.slave bus
);

    localparam int unsigned CW = cntWidth(DATA_WIDTH);

    if (SHIFT_AMT >= DATA_WIDTH) begin : g_bad_shift_amt
        $error("serial_shift_responder: SHIFT_AMT must be below DATA_WIDTH");
    end

    state_t                state,      state_n;
    logic [CW-1:0]         count,      count_n;
    logic [DATA_WIDTH-1:0] shift_reg,  shift_reg_n;
    logic [DATA_WIDTH-1:0] result_r,   result_n;
    logic                  out_valid,  out_valid_n;
    logic                  in_ready,   in_ready_n;
    logic                  busy_r,     busy_n;
`ifdef SERIAL_SHIFT_OVF_EN
    logic                  ovf,        ovf_n;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
            result_r  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy_r    <= 1'b0;
`ifdef SERIAL_SHIFT_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            count     <= count_n;
            shift_reg <= shift_reg_n;
            result_r  <= result_n;
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
            busy_r    <= busy_n;
`ifdef SERIAL_SHIFT_OVF_EN
            ovf       <= ovf_n;
`endif
        end
    end

    // Every output is registered, so next-state logic also computes the
    // next value of each output flag alongside the state.
    always_comb begin
        state_n     = state;
        count_n     = count;
        shift_reg_n = shift_reg;
        result_n    = result_r;
        out_valid_n = out_valid;
        in_ready_n  = in_ready;
`ifdef SERIAL_SHIFT_OVF_EN
        ovf_n       = ovf;
`endif

        unique case (state)
            IDLE: begin
                in_ready_n = 1'b1;
                if (bus.inValid && in_ready) begin
                    in_ready_n  = 1'b0;
                    shift_reg_n = bus.inputSignal;
                    count_n     = CW'(SHIFT_AMT);
`ifdef SERIAL_SHIFT_OVF_EN
                    ovf_n       = 1'b0;
`endif
                    if (SHIFT_AMT == 0) begin
                        state_n     = DONE;
                        result_n    = bus.inputSignal;
                        out_valid_n = 1'b1;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end

            SHIFT: begin
                shift_reg_n = shift_reg << 1;
`ifdef SERIAL_SHIFT_OVF_EN
                ovf_n       = ovf | shift_reg[DATA_WIDTH-1];
`endif
                if (count != '0) begin
                    count_n = count - CW'(1);
                end
                // Last shift: publish the shifted value directly so the result
                // appears on the same edge the count reaches zero.
                if (count <= CW'(1)) begin
                    state_n     = DONE;
                    result_n    = shift_reg << 1;
                    out_valid_n = 1'b1;
                end
            end

            DONE: begin
                out_valid_n = 1'b1;
                if (out_valid && bus.outReady) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                end
            end

            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
                in_ready_n  = 1'b0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = out_valid;
    assign bus.result   = result_r;
    assign bus.busy     = busy_r;
`ifdef SERIAL_SHIFT_OVF_EN
    assign bus.overflow = ovf;
`endif

endmodule

// File: tb/tb_serial_shift_responder.sv
// Testbench: tb_serial_shift_responder
// Purpose  : Self-checking bench for serial_shift_responder. A SHIFT_AMT=5
//            instance takes a table of directed operands plus hand-written
//            stall, mid-shift reset and streaming sequences; a SHIFT_AMT=0
//            instance covers the zero-distance pass-through.
// Build option: SERIAL_SHIFT_OVF_EN enables the overflow checks.
module tb_serial_shift_responder;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    serial_shift_responder_if #(.DATA_WIDTH(32)) bus  ();
    serial_shift_responder_if #(.DATA_WIDTH(32)) bus0 ();

    serial_shift_responder #(.DATA_WIDTH(32), .SHIFT_AMT(5)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    serial_shift_responder #(.DATA_WIDTH(32), .SHIFT_AMT(0)) dut0 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus0.slave)
    );

    typedef struct {
        logic [31:0] operand;
        logic [31:0] expected;
        logic        ovf;
    } vec_t;

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic get_ovf();
`ifdef SERIAL_SHIFT_OVF_EN
        return bus.overflow;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the result handshake.
    task automatic do_op(input logic [31:0] op, output logic [31:0] res,
                         output logic ov, output int lat, output logic ok);
        int w;
        w   = 0;
        ok  = 1'b1;
        ov  = 1'b0;
        lat = 0;
        res = '0;
        while (!bus.inReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.inReady) begin
            ok = 1'b0;
            return;
        end
        bus.inputSignal = op;
        bus.inValid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.inValid     = 1'b0;
        bus.inputSignal = $urandom;
        while (!bus.outValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.outValid) begin
            ok = 1'b0;
            return;
        end
        res = bus.result;
        ov  = get_ovf();
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [8];
        logic [31:0] res;
        logic        ov;
        int          lat;
        logic        ok;
        int          w;

        vecs[0] = '{32'h00000111, 32'h00002220, 1'b0};
        vecs[1] = '{32'h0FFFFFFF, 32'hFFFFFFE0, 1'b1};
        vecs[2] = '{32'h07FFFFFF, 32'hFFFFFFE0, 1'b0};
        vecs[3] = '{32'hDEADBEEF, 32'hD5B7DDE0, 1'b1};
        vecs[4] = '{32'h80000000, 32'h00000000, 1'b1};
        vecs[5] = '{32'h00000001, 32'h00000020, 1'b0};
        vecs[6] = '{32'hF8000000, 32'h00000000, 1'b1};
        vecs[7] = '{32'h04000000, 32'h80000000, 1'b0};

        bus.inValid      = 1'b0;
        bus.inputSignal  = '0;
        bus.outReady     = 1'b0;
        bus0.inValid     = 1'b0;
        bus0.inputSignal = '0;
        bus0.outReady    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_inReady",  32'(bus.inReady),  32'd0);
        check("rst_outValid", 32'(bus.outValid), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_result",   bus.result,        32'h0);
        check("rst_ovf",      32'(get_ovf()),    32'd0);
        resetN = 1'b1;
        @(negedge clk);
        check("post_rst_inReady", 32'(bus.inReady), 32'd1);

        // Directed table
        for (int unsigned i = 0; i < 8; i++) begin
            do_op(vecs[i].operand, res, ov, lat, ok);
            check($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_result", i), res, vecs[i].expected);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
`ifdef SERIAL_SHIFT_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
`endif
            check($sformatf("vec%0d_inReady_after", i), 32'(bus.inReady), 32'd1);
            check($sformatf("vec%0d_outValid_after", i), 32'(bus.outValid), 32'd0);
        end

        // Back-pressure in DONE for 10 cycles with a competing inValid
        bus.inputSignal = 32'h12345678;
        bus.inValid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.inValid = 1'b0;
        check("stall_busy_shift", 32'(bus.busy), 32'd1);
        w = 0;
        while (!bus.outValid && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("stall_latency", 32'(w), 32'd5);
        for (int unsigned c = 0; c < 10; c++) begin
            bus.inValid     = 1'b1;
            bus.inputSignal = $urandom;
            @(negedge clk);
            check("stall_outValid", 32'(bus.outValid), 32'd1);
            check("stall_result",   bus.result,        32'h468ACF00);
            check("stall_inReady",  32'(bus.inReady),  32'd0);
        end
`ifdef SERIAL_SHIFT_OVF_EN
        check("stall_ovf", 32'(get_ovf()), 32'd1);
`endif
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
        check("release_outValid", 32'(bus.outValid), 32'd0);
        check("release_inReady",  32'(bus.inReady),  32'd1);
        check("release_busy",     32'(bus.busy),     32'd0);
        @(negedge clk);
        check("release_no_accept", 32'(bus.busy), 32'd0);

        // Reset mid-SHIFT (count=2)
        bus.inputSignal = 32'hFFFFFFFF;
        bus.inValid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.inValid = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        check("midrst_outValid", 32'(bus.outValid), 32'd0);
        check("midrst_result",   bus.result,        32'h0);
        check("midrst_inReady",  32'(bus.inReady),  32'd0);
        check("midrst_busy",     32'(bus.busy),     32'd0);
        do_op(32'h00000222, res, ov, lat, ok);
        check("midrst_next_done",    32'(ok),  32'd1);
        check("midrst_next_result",  res,      32'h00004440);
        check("midrst_next_latency", 32'(lat), 32'd5);
`ifdef SERIAL_SHIFT_OVF_EN
        check("midrst_next_ovf", 32'(ov), 32'd0);
`endif

        // Streaming ramp with inValid/outReady held high
        begin
            int unsigned send, rcv, cyc, last;
            logic        accept_next;
            logic [31:0] exp_val;
            send = 0;
            rcv  = 0;
            cyc  = 0;
            last = 0;
            bus.inputSignal = '0;
            bus.inValid     = 1'b1;
            bus.outReady    = 1'b1;
            while (rcv < 1000 && cyc < 8000) begin
                if (bus.outValid) begin
                    exp_val = 32'(rcv * 32'h111) << 5;
                    check("ramp_result", bus.result, exp_val);
                    if (rcv > 0) check("ramp_spacing", 32'(cyc - last), 32'd7);
                    last = cyc;
                    rcv++;
                end
                accept_next = bus.inValid && bus.inReady;
                @(negedge clk);
                cyc++;
                if (accept_next) begin
                    send++;
                    if (send < 1000) bus.inputSignal = 32'(send * 32'h111);
                    else             bus.inValid     = 1'b0;
                end
            end
            bus.inValid  = 1'b0;
            bus.outReady = 1'b0;
            check("ramp_count", 32'(rcv), 32'd1000);
        end

        // Zero-distance instance
        w = 0;
        while (!bus0.inReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("z_inReady", 32'(bus0.inReady), 32'd1);
        bus0.inputSignal = 32'hDEADBEEF;
        bus0.inValid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.inValid     = 1'b0;
        bus0.inputSignal = 32'h0;
        check("z_outValid", 32'(bus0.outValid), 32'd1);
        check("z_result",   bus0.result,        32'hDEADBEEF);
        check("z_busy",     32'(bus0.busy),     32'd1);
        check("z_inReady_low", 32'(bus0.inReady), 32'd0);
`ifdef SERIAL_SHIFT_OVF_EN
        check("z_ovf", 32'(bus0.overflow), 32'd0);
`endif
        bus0.outReady = 1'b1;
        @(negedge clk);
        bus0.outReady = 1'b0;
        check("z_release_outValid", 32'(bus0.outValid), 32'd0);
        check("z_release_inReady",  32'(bus0.inReady),  32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
